// File: rtl/cam_feeder_pkg.sv
// rtl/cam_feeder_pkg.sv - shared types, defaults and colour-bar constants for the camera pixel feeder
package cam_feeder_pkg;

  localparam int CAM_WORD_W       = 32;
  localparam int LINE_PIXELS_DEF  = 800;
  localparam int FRAME_PIXELS_DEF = 480000;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb30_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam rgb30_t BAR_WHITE   = '{r: 10'h3FF, g: 10'h3FF, b: 10'h3FF};
  localparam rgb30_t BAR_YELLOW  = '{r: 10'h3FF, g: 10'h3FF, b: 10'h000};
  localparam rgb30_t BAR_CYAN    = '{r: 10'h000, g: 10'h3FF, b: 10'h3FF};
  localparam rgb30_t BAR_GREEN   = '{r: 10'h000, g: 10'h3FF, b: 10'h000};
  localparam rgb30_t BAR_MAGENTA = '{r: 10'h3FF, g: 10'h000, b: 10'h3FF};
  localparam rgb30_t BAR_RED     = '{r: 10'h3FF, g: 10'h000, b: 10'h000};
  localparam rgb30_t BAR_BLUE    = '{r: 10'h000, g: 10'h000, b: 10'h3FF};
  localparam rgb30_t BAR_BLACK   = '{r: 10'h000, g: 10'h000, b: 10'h000};

  function automatic rgb30_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  function automatic logic [CAM_WORD_W-1:0] pack_word(input rgb30_t px);
    return {2'b00, px};
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// rtl/feeder_fifo.sv - show-ahead ring buffer: head word is readable without a pop
module feeder_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 30
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push && !clear && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && !clear && (count_q != '0);

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/cam_pixel_feeder.sv
// rtl/cam_pixel_feeder.sv - camera pixel request responder; colour bars under CAM_FEEDER_TEST_PATTERN_EN
module cam_pixel_feeder
  import cam_feeder_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int LINE_PIXELS  = LINE_PIXELS_DEF,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_src_valid,
  input  logic [29:0]           i_src_data,
  output logic                  o_src_ready,
  input  logic                  i_req,
  output logic [CAM_WORD_W-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_underrun,
  input  logic                  i_clr_underrun,
  input  logic                  i_test_mode,
  output logic [9:0]            o_col,
  output logic [19:0]           o_pix_count,
  output logic                  o_frame_done
);
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [19:0] PIX_LAST = 20'(FRAME_PIXELS - 1);
  localparam logic [9:0]  COL_LAST = 10'(LINE_PIXELS - 1);

  state_t                  state_q, state_d;
  logic                    run, req_act, push, pop, underrun_set;
  logic                    fifo_empty, pattern_on;
  logic [CW-1:0]           fifo_count;
  logic [29:0]             fifo_head;
  logic [CAM_WORD_W-1:0]   pattern_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    run     = (state_q == RUN);
    if (i_flush) state_d = RUN;
  end

  assign o_src_ready  = run && (fifo_count != CW'(DEPTH)) && !i_flush;
  assign push         = i_src_valid && o_src_ready;
  assign req_act      = run && i_req && !i_flush;
  // The test pattern stands in for the FIFO, so requests neither drain it nor underrun.
  assign pop          = req_act && !fifo_empty && !pattern_on;
  assign underrun_set = req_act && fifo_empty && !pattern_on;
  assign o_empty      = fifo_empty;

  feeder_fifo #(.DEPTH(DEPTH), .WIDTH(30)) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .clear     (i_flush),
    .push      (push),
    .push_data (i_src_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef CAM_FEEDER_TEST_PATTERN_EN
  localparam int BAR_W = (LINE_PIXELS / 8 > 0) ? LINE_PIXELS / 8 : 1;
  logic [9:0] bar_idx;
  logic [2:0] bar_sel;
  assign pattern_on   = run && i_test_mode;
  assign bar_idx      = o_col / 10'(BAR_W);
  assign bar_sel      = (bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0];
  assign pattern_word = pack_word(bar_colour(bar_sel));
`else
  logic unused_test_mode;
  assign unused_test_mode = i_test_mode;
  assign pattern_on       = 1'b0;
  assign pattern_word     = '0;
`endif

  always_comb begin
    o_data = '0;
    if (pattern_on)       o_data = pattern_word;
    else if (!fifo_empty) o_data = pack_word(rgb30_t'(fifo_head));
  end

  // An empty-slot request still consumes a frame position.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_count  <= '0;
      o_col        <= '0;
      o_frame_done <= 1'b0;
    end else if (i_flush) begin
      o_pix_count  <= '0;
      o_col        <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (req_act) begin
        o_frame_done <= (o_pix_count == PIX_LAST);
        o_pix_count  <= (o_pix_count == PIX_LAST) ? 20'd0 : o_pix_count + 20'd1;
        o_col        <= (o_col == COL_LAST) ? 10'd0 : o_col + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            o_underrun <= 1'b0;
    else if (underrun_set)   o_underrun <= 1'b1;
    else if (i_clr_underrun) o_underrun <= 1'b0;
  end

endmodule

// File: tb/tb_cam_pixel_feeder.sv
// tb/tb_cam_pixel_feeder.sv - self-checking bench for cam_pixel_feeder with a queue scoreboard
module tb_cam_pixel_feeder;
  localparam int DEPTH = 8;
  localparam int LINE  = 16;
  localparam int FRAME = 48;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_src_valid, i_req, i_clr_underrun, i_test_mode;
  logic [29:0] i_src_data;
  logic        o_src_ready, o_empty, o_underrun, o_frame_done;
  logic [31:0] o_data;
  logic [9:0]  o_col;
  logic [19:0] o_pix_count;

  int errors = 0;
  int checks = 0;

  logic [29:0] q[$];
  bit          run_m, und_m, fd_m, tm_m;
  int          pix_m, col_m;
  logic [31:0] bars [8];

  cam_pixel_feeder #(.DEPTH(DEPTH), .LINE_PIXELS(LINE), .FRAME_PIXELS(FRAME)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_flush        (i_flush),
    .i_src_valid    (i_src_valid),
    .i_src_data     (i_src_data),
    .o_src_ready    (o_src_ready),
    .i_req          (i_req),
    .o_data         (o_data),
    .o_empty        (o_empty),
    .o_underrun     (o_underrun),
    .i_clr_underrun (i_clr_underrun),
    .i_test_mode    (i_test_mode),
    .o_col          (o_col),
    .o_pix_count    (o_pix_count),
    .o_frame_done   (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit pat_m();
`ifdef CAM_FEEDER_TEST_PATTERN_EN
    return run_m && tm_m;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data();
    if (pat_m())              return bars[col_m / (LINE / 8)];
    else if (q.size() != 0)   return {2'b00, q[0]};
    else                      return 32'h0;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_ready"},    {31'd0, o_src_ready},  {31'd0, run_m && (q.size() < DEPTH)});
    chk({tag, "_empty"},    {31'd0, o_empty},      {31'd0, q.size() == 0});
    chk({tag, "_data"},     o_data,                exp_data());
    chk({tag, "_col"},      {22'd0, o_col},        32'(col_m));
    chk({tag, "_pix"},      {12'd0, o_pix_count},  32'(pix_m));
    chk({tag, "_underrun"}, {31'd0, o_underrun},   {31'd0, und_m});
    chk({tag, "_fdone"},    {31'd0, o_frame_done}, {31'd0, fd_m});
  endtask

  task automatic drive(input string tag, input bit v, input logic [29:0] d, input bit r, input bit clr);
    bit acc, fd_n, und_set;
    i_src_valid    = v;
    i_src_data     = d;
    i_req          = r;
    i_clr_underrun = clr;
    #1;
    check_outputs(tag);
    acc     = v && run_m && (q.size() < DEPTH);
    fd_n    = 1'b0;
    und_set = 1'b0;
    if (run_m && r) begin
      if (!pat_m()) begin
        if (q.size() > 0) void'(q.pop_front());
        else              und_set = 1'b1;
      end
      fd_n  = (pix_m == FRAME - 1);
      pix_m = fd_n ? 0 : pix_m + 1;
      col_m = (col_m == LINE - 1) ? 0 : col_m + 1;
    end
    if (acc) q.push_back(d);
    und_m = und_set ? 1'b1 : (clr ? 1'b0 : und_m);
    fd_m  = fd_n;
    @(posedge i_clk); #1;
  endtask

  task automatic do_flush();
    i_flush     = 1'b1;
    i_src_valid = 1'b1;
    i_req       = 1'b1;
    #1;
    chk("flush_ready", {31'd0, o_src_ready}, 32'd0);
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    q.delete();
    run_m = 1'b1;
    pix_m = 0;
    col_m = 0;
    fd_m  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    i_rst_n = 1'b0;
    #1;
    q.delete();
    run_m = 1'b0;
    und_m = 1'b0;
    fd_m  = 1'b0;
    pix_m = 0;
    col_m = 0;
    check_outputs(tag);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    bars[0] = 32'h3FFFFFFF; bars[1] = 32'h3FFFFC00; bars[2] = 32'h000FFFFF; bars[3] = 32'h000FFC00;
    bars[4] = 32'h3FF003FF; bars[5] = 32'h3FF00000; bars[6] = 32'h000003FF; bars[7] = 32'h00000000;
    i_rst_n = 1'b0; i_flush = 1'b0; i_src_valid = 1'b0; i_src_data = '0;
    i_req = 1'b0; i_clr_underrun = 1'b0; i_test_mode = 1'b0;
    tm_m = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    do_reset("reset");

    // IDLE: pushes and requests are ignored
    repeat (3) drive("idle_push", 1'b1, 30'($urandom), 1'b0, 1'b0);
    drive("idle_req", 1'b0, '0, 1'b1, 1'b0);

    do_flush();
    drive("push_r", 1'b1, 30'h3FF00000, 1'b0, 1'b0);
    drive("push_g", 1'b1, 30'h000FFC00, 1'b0, 1'b0);
    drive("pop_r",  1'b0, '0, 1'b1, 1'b0);
    drive("head_g", 1'b0, '0, 1'b0, 1'b0);
    drive("pop_g",  1'b0, '0, 1'b1, 1'b0);

    // fill to full, then pop and push together while full
    repeat (DEPTH) drive("fill", 1'b1, 30'($urandom), 1'b0, 1'b0);
    drive("full_push", 1'b1, 30'($urandom), 1'b0, 1'b0);
    drive("full_both", 1'b1, 30'($urandom), 1'b1, 1'b0);
    drive("ready_back", 1'b0, '0, 1'b0, 1'b0);
    repeat (DEPTH - 1) drive("drain", 1'b0, '0, 1'b1, 1'b0);

    // underrun, set-beats-clear, then clear
    drive("under_req",  1'b0, '0, 1'b1, 1'b0);
    drive("under_set",  1'b0, '0, 1'b0, 1'b0);
    drive("under_both", 1'b0, '0, 1'b1, 1'b1);
    drive("under_hold", 1'b0, '0, 1'b0, 1'b0);
    drive("under_clr",  1'b0, '0, 1'b0, 1'b1);
    drive("under_gone", 1'b0, '0, 1'b0, 1'b0);

    // two full frames with continuous supply
    do_flush();
    repeat (4) drive("prefill", 1'b1, 30'($urandom), 1'b0, 1'b0);
    repeat (2 * FRAME + 3) drive("frame", 1'b1, 30'($urandom), 1'b1, 1'b0);

    // test mode: bars with the macro, ignored without it
    i_test_mode = 1'b1;
    tm_m = 1'b1;
    repeat (LINE + 2) drive("tmode", 1'b1, 30'($urandom), 1'b1, 1'b0);
    i_test_mode = 1'b0;
    tm_m = 1'b0;
    repeat (DEPTH + 2) drive("tmode_off", 1'b0, '0, 1'b1, 1'b0);

    // reset mid-frame discards buffered data
    do_flush();
    repeat (5) drive("pre_rst", 1'b1, 30'($urandom), 1'b1, 1'b0);
    do_reset("mid_reset");
    drive("post_rst", 1'b1, 30'($urandom), 1'b1, 1'b0);
    do_flush();
    drive("fresh_push", 1'b1, 30'h0ABCDEF1, 1'b0, 1'b0);
    drive("fresh_head", 1'b0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
